// File: rtl/slot_alloc_pkg.sv
// Shared sizing, FSM state type and priority-pick helper for the slot allocator.
package slot_alloc_pkg;

    localparam int unsigned N_SRC   = 7;
    localparam int unsigned N_SLOT  = 3;
    localparam int unsigned DW      = 8;
    localparam int unsigned SRC_IW  = $clog2(N_SRC);
    localparam int unsigned SLOT_IW = $clog2(N_SLOT);
    localparam int unsigned OCC_W   = $clog2(N_SLOT + 1);
    localparam int unsigned PICK_W  = (N_SRC > N_SLOT) ? N_SRC : N_SLOT;
    localparam int unsigned PICK_IW = $clog2(PICK_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALLOC = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic               found;
        logic [PICK_IW-1:0] idx;
    } pick_t;

    // Lowest-index set bit; scanning downward lets the lowest hit win.
    function automatic pick_t lowest_set(input logic [PICK_W-1:0] mask);
        pick_t r;
        r = '0;
        for (int i = int'(PICK_W) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r.found = 1'b1;
                r.idx   = PICK_IW'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/slot_alloc_ctrl_prio_pick.sv
// Parameterised lowest-index priority encoder.
module prio_pick
    import slot_alloc_pkg::*;
#(
    parameter int unsigned W  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [W-1:0]  mask,
    output logic          found_c,
    output logic [IW-1:0] idx_c
);

    pick_t pick_c;

    always_comb begin
        pick_c  = lowest_set(PICK_W'(mask));
        found_c = pick_c.found;
        idx_c   = IW'(pick_c.idx);
    end

endmodule

// File: rtl/slot_alloc_ctrl.sv
// Sequential batch allocator: one source resolved per cycle into a small slot pool,
// with merge of already-resident values and an always-on release port.
module slot_alloc_ctrl
    import slot_alloc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [N_SRC*DW-1:0]    src_data,
    input  logic                   rel_valid,
    input  logic [SLOT_IW-1:0]     rel_slot,
    output logic                   busy,
    output logic                   grant_valid,
    output logic [SRC_IW-1:0]      grant_src,
    output logic [SLOT_IW-1:0]     grant_slot,
    output logic                   grant_new,
    output logic                   stall,
    output logic                   done,
    output logic [N_SLOT-1:0]      slot_valid,
    output logic [N_SLOT*DW-1:0]   slot_data,
    output logic [OCC_W-1:0]       occupancy
);

    state_t                        state_q, state_d;
    logic [N_SRC-1:0][DW-1:0]      src_q, src_d;
    logic [N_SRC-1:0]              pending_q, pending_d;
    logic [N_SLOT-1:0][DW-1:0]     slot_q, data_d;
    logic [N_SLOT-1:0]             valid_d;
    logic                          gvalid_d, gnew_d, stall_d, done_d;
    logic [SRC_IW-1:0]             gsrc_d;
    logic [SLOT_IW-1:0]            gslot_d;

    logic [N_SLOT-1:0]             rel_mask_c, eff_valid_c, match_mask_c;
    logic                          src_found_c, free_found_c;
    logic [SRC_IW-1:0]             src_idx_c;
    logic [SLOT_IW-1:0]            free_idx_c;
    logic [DW-1:0]                 cur_c;
    pick_t                         match_c;

    // Release applied first: a released slot is free but never matchable this cycle.
    always_comb begin
        rel_mask_c = '0;
        for (int j = 0; j < int'(N_SLOT); j++) begin
            rel_mask_c[j] = rel_valid && (rel_slot == SLOT_IW'(j));
        end
        eff_valid_c = slot_valid & ~rel_mask_c;
    end

    prio_pick #(.W(N_SRC), .IW(SRC_IW)) u_pick_src (
        .mask    (pending_q),
        .found_c (src_found_c),
        .idx_c   (src_idx_c)
    );

    prio_pick #(.W(N_SLOT), .IW(SLOT_IW)) u_pick_free (
        .mask    (~eff_valid_c),
        .found_c (free_found_c),
        .idx_c   (free_idx_c)
    );

    always_comb begin
        cur_c = src_q[src_idx_c];
        for (int j = 0; j < int'(N_SLOT); j++) begin
            match_mask_c[j] = eff_valid_c[j] && (slot_q[j] == cur_c);
        end
        match_c = lowest_set(PICK_W'(match_mask_c));
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        pending_d = pending_q;
        valid_d   = eff_valid_c;
        for (int j = 0; j < int'(N_SLOT); j++) begin
            data_d[j] = rel_mask_c[j] ? '0 : slot_q[j];
        end
        gvalid_d  = 1'b0;
        gsrc_d    = grant_src;
        gslot_d   = grant_slot;
        gnew_d    = grant_new;
        stall_d   = 1'b0;
        done_d    = (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d = src_data;
                    for (int i = 0; i < int'(N_SRC); i++) begin
                        pending_d[i] = (src_data[i*DW +: DW] != '0);
                    end
                    state_d = (pending_d != '0) ? ALLOC : DONE;
                end
            end
            ALLOC: begin
                if (src_found_c) begin
                    if (match_c.found) begin
                        gvalid_d             = 1'b1;
                        gsrc_d               = src_idx_c;
                        gslot_d              = SLOT_IW'(match_c.idx);
                        gnew_d               = 1'b0;
                        pending_d[src_idx_c] = 1'b0;
                    end else if (free_found_c) begin
                        gvalid_d             = 1'b1;
                        gsrc_d               = src_idx_c;
                        gslot_d              = free_idx_c;
                        gnew_d               = 1'b1;
                        valid_d[free_idx_c]  = 1'b1;
                        data_d[free_idx_c]   = cur_c;
                        pending_d[src_idx_c] = 1'b0;
                    end else begin
                        stall_d = 1'b1;
                    end
                end
                if (pending_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_q       <= '0;
            pending_q   <= '0;
            slot_q      <= '0;
            slot_valid  <= '0;
            grant_valid <= 1'b0;
            grant_src   <= '0;
            grant_slot  <= '0;
            grant_new   <= 1'b0;
            stall       <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            pending_q   <= pending_d;
            slot_q      <= data_d;
            slot_valid  <= valid_d;
            grant_valid <= gvalid_d;
            grant_src   <= gsrc_d;
            grant_slot  <= gslot_d;
            grant_new   <= gnew_d;
            stall       <= stall_d;
            done        <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign slot_data = slot_q;

    always_comb begin
        occupancy = '0;
        for (int j = 0; j < int'(N_SLOT); j++) begin
            occupancy = occupancy + OCC_W'(slot_valid[j]);
        end
    end

endmodule

// File: tb/tb_slot_alloc_ctrl.sv
// Scoreboard bench for slot_alloc_ctrl: stimulus queues expected grants/done events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_slot_alloc_ctrl;
    import slot_alloc_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [N_SRC*DW-1:0]   src_data = '0;
    logic                  rel_valid = 1'b0;
    logic [SLOT_IW-1:0]    rel_slot = '0;
    logic                  busy, grant_valid, grant_new, stall, done;
    logic [SRC_IW-1:0]     grant_src;
    logic [SLOT_IW-1:0]    grant_slot;
    logic [N_SLOT-1:0]     slot_valid;
    logic [N_SLOT*DW-1:0]  slot_data;
    logic [OCC_W-1:0]      occupancy;

    always #5 clk = ~clk;

    slot_alloc_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .src_data    (src_data),
        .rel_valid   (rel_valid),
        .rel_slot    (rel_slot),
        .busy        (busy),
        .grant_valid (grant_valid),
        .grant_src   (grant_src),
        .grant_slot  (grant_slot),
        .grant_new   (grant_new),
        .stall       (stall),
        .done        (done),
        .slot_valid  (slot_valid),
        .slot_data   (slot_data),
        .occupancy   (occupancy)
    );

    typedef struct {
        bit is_done;
        int src;
        int slot;
        int is_new;
        int occ;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N_SRC*DW-1:0] pk(input int v0, input int v1, input int v2,
                                                input int v3, input int v4, input int v5,
                                                input int v6);
        return {DW'(v6), DW'(v5), DW'(v4), DW'(v3), DW'(v2), DW'(v1), DW'(v0)};
    endfunction

    function automatic int slot_val(input int j);
        logic [N_SLOT*DW-1:0] v;
        v = slot_data;
        return int'(v[j*DW +: DW]);
    endfunction

    task automatic push_g(input int s, input int sl, input int nw);
        ev_t e;
        e = '{is_done: 1'b0, src: s, slot: sl, is_new: nw, occ: 0};
        exp_q.push_back(e);
    endtask

    task automatic push_d(input int occ);
        ev_t e;
        e = '{is_done: 1'b1, src: 0, slot: 0, is_new: 0, occ: occ};
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [N_SRC*DW-1:0] v);
        src_data = v;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic rel(input int s);
        rel_valid = 1'b1;
        rel_slot  = SLOT_IW'(s);
        tick();
        rel_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 40);
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic pop_cmp(input bit kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d src %0d slot %0d, required no event (t=%0t)",
                     kind, grant_src, grant_slot, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.is_done);
            if (!kind) begin
                check("grant_src", grant_src, e.src);
                check("grant_slot", grant_slot, e.slot);
                check("grant_new", grant_new, e.is_new);
            end else begin
                check("done_occupancy", occupancy, e.occ);
            end
        end
    endtask

    // Monitor: compares every presented grant/done against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && grant_valid) pop_cmp(1'b0);
            if (rst_n && done)        pop_cmp(1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_grant_valid"}, grant_valid, 0);
        check({tag, "_grant_src"}, grant_src, 0);
        check({tag, "_grant_slot"}, grant_slot, 0);
        check({tag, "_grant_new"}, grant_new, 0);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_slot_valid"}, slot_valid, 0);
        check({tag, "_slot_data"}, slot_data, 0);
        check({tag, "_occupancy"}, occupancy, 0);
    endtask

    initial begin
        int n;
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic fill: three allocations, fourth source stalls on a full pool
        push_g(3, 0, 1); push_g(4, 1, 1); push_g(5, 2, 1);
        go(pk(0, 0, 0, 13, 14, 15, 16));
        repeat (4) tick();
        check("fill_stall", stall, 1);
        check("fill_busy", busy, 1);
        check("fill_no_done", done, 0);
        check("fill_occ", occupancy, 3);

        // Release slot 1: same-cycle reallocation to the stalled source
        push_g(6, 1, 1); push_d(3);
        rel(1);
        drain();
        check("rel_slot1_data", slot_val(1), 16);
        check("rel_occ", occupancy, 3);
        check("rel_stall_clear", stall, 0);

        // Prepare slots {13,14,0}
        rel(2);
        rel(1);
        check("prep_valid", slot_valid, 3'b001);
        push_g(0, 1, 1); push_d(2);
        go(pk(14, 0, 0, 0, 0, 0, 0));
        wait_done(n);
        check("single_latency", n, 2);
        drain();

        // Merge batch
        push_g(0, 1, 0); push_g(2, 2, 1); push_g(3, 0, 0); push_d(3);
        go(pk(14, 0, 20, 13, 0, 0, 0));
        wait_done(n);
        check("merge_latency", n, 4);
        drain();
        check("merge_slot2", slot_val(2), 20);

        // All-zero batch
        push_d(3);
        go(pk(0, 0, 0, 0, 0, 0, 0));
        wait_done(n);
        check("zero_latency", n, 1);
        drain();
        check("zero_slot0", slot_val(0), 13);
        check("zero_slot1", slot_val(1), 14);
        check("zero_slot2", slot_val(2), 20);

        // Baseline run from an empty pool
        rel(0); rel(1); rel(2);
        check("empty_occ", occupancy, 0);
        push_g(1, 0, 1); push_g(3, 1, 1); push_d(2);
        go(pk(0, 7, 0, 9, 0, 0, 0));
        wait_done(n);
        check("base_latency", n, 3);
        drain();
        check("base_valid", slot_valid, 3'b011);

        // Same batch with start while busy, empty-slot and out-of-range releases
        rel(0); rel(1);
        push_g(1, 0, 1); push_g(3, 1, 1); push_d(2);
        go(pk(0, 7, 0, 9, 0, 0, 0));
        src_data  = pk(85, 85, 85, 85, 85, 85, 85);
        start     = 1'b1;
        rel_valid = 1'b1;
        rel_slot  = 2'd2;
        tick();
        start     = 1'b0;
        rel_slot  = 2'd3;
        tick();
        rel_valid = 1'b0;
        src_data  = '0;
        wait_done(n);
        check("busy_latency", n, 1);
        drain();
        check("busy_valid", slot_valid, 3'b011);
        check("busy_slot0", slot_val(0), 7);
        check("busy_slot1", slot_val(1), 9);
        check("busy_idle", busy, 0);

        // Async reset after two grants
        rel(0); rel(1);
        push_g(0, 0, 1); push_g(1, 1, 1);
        go(pk(1, 2, 3, 4, 0, 0, 0));
        tick();
        tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        check("midreset_queue", exp_q.size(), 0);
        tick();
        rst_n = 1'b1;
        tick();

        push_g(2, 0, 1); push_g(6, 1, 1); push_d(2);
        go(pk(0, 0, 11, 0, 0, 0, 12));
        wait_done(n);
        check("post_reset_latency", n, 3);
        drain();
        check("post_reset_slot0", slot_val(0), 11);
        check("post_reset_slot1", slot_val(1), 12);
        check("post_reset_occ", occupancy, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/slot_alloc_ctrl.md
Name: slot_alloc_ctrl

Overview:
Batch allocator that maps a set of source entries onto a small pool of destination slots, one grant per cycle.
- Nonzero source values are placed into free slots.
- A value already resident in a slot is merged (deduplicated) instead of taking a second slot.
- Slots are freed by an external release interface.
- Sits between the source capture registers and the slot array in the core, and sequences the fill that was previously evaluated combinationally.

Parameters:
N_SRC, 7, number of source entries per batch
N_SLOT, 3, number of destination slots
DW, 8, data width of a source value / slot tag (value 0 = empty/invalid)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; captures src_data and begins a batch; ignored unless in IDLE
src_data  input  N_SRC*DW  packed source values, entry i at [i*DW +: DW]
rel_valid  input  1  release request
rel_slot  input  $clog2(N_SLOT)  slot to free
busy  output  1  high in ALLOC and DONE states
grant_valid  output  1  registered pulse, one source resolved this cycle
grant_src  output  $clog2(N_SRC)  source index resolved
grant_slot  output  $clog2(N_SLOT)  slot assigned or merged into
grant_new  output  1  1 = new allocation, 0 = merge into existing slot
stall  output  1  pending source exists but no free or matching slot
done  output  1  one-cycle pulse at batch completion
slot_valid  output  N_SLOT  occupancy mask
slot_data  output  N_SLOT*DW  slot contents, slot j at [j*DW +: DW]
occupancy  output  $clog2(N_SLOT+1)  population count of slot_valid

Behaviour:
- Reset (rst_n low, async): state=IDLE; pending=0; captured sources=0; all outputs 0, including slot_valid, slot_data and occupancy.
- FSM states: IDLE, ALLOC, DONE.
- IDLE:
  - On start, latch src_data into src_q.
  - pending[i] = (src_q[i] != 0).
  - Go to ALLOC, or to DONE if all entries are zero.
- ALLOC, each cycle:
  - Pick i = lowest-index set bit of pending (fixed priority, index 0 first).
  - Effective slot state is the registered slot state with this cycle's valid release already applied.
  - Match: if any effective-valid slot j has slot_data[j]==src_q[i], merge into the lowest such j. Clear pending[i]. Registered grant next edge with grant_new=0.
  - No match, free slot exists: allocate the lowest free j. slot_data[j]<=src_q[i], slot_valid[j]<=1, clear pending[i], grant_new=1.
  - No match, no free slot: stall=1, no grant, pending unchanged. Retry every cycle.
  - When the last pending bit clears, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Latency:
  - start at edge k: first grant_valid visible after edge k+1.
  - Best case, batch of M nonzero sources with no stalls: done asserts after edge k+M+1.
- Release:
  - Accepted in any state.
  - If slot_valid[rel_slot]: slot_valid<=0 and slot_data<=0.
  - Release of an empty slot or an out-of-range index: ignored.
- Simultaneous release and allocation: the released slot is free for the same-cycle decision and may be reallocated that cycle; it is not matchable for merge.
- start while busy: ignored, with no effect on pending or src_q.
- Duplicate values inside one batch: the first occurrence allocates, later occurrences merge.
- occupancy tracks slot_valid combinationally from registered state; range 0..N_SLOT.
- Slot contents persist across batches until released.

Decomposition:
- Package slot_alloc_pkg holds:
  - localparams SRC_IW = $clog2(N_SRC) and SLOT_IW = $clog2(N_SLOT);
  - the FSM state enum {IDLE, ALLOC, DONE};
  - a function lowest_set(mask) returning index and found flag.
- One sub-module: prio_pick, a parameterised lowest-index priority encoder, instanced twice: pending select and free-slot select.

Test Plan:
- Basic fill:
  - Stimulus: src={0,0,0,13,14,15,16} (idx0..6), start.
  - Required response:
    - grants (src3,slot0,new), (src4,slot1,new), (src5,slot2,new);
    - src6 then holds stall=1 with busy=1 and done not asserted.
- Release unblocks:
  - Stimulus: continue the basic-fill case, rel_valid with rel_slot=1 for one cycle.
  - Required response: same-cycle decision grants (src6,slot1,new); slot_data[1]=16; done pulses next cycle; occupancy=3.
- Merge:
  - Stimulus: slots hold {13,14,0}; src={14,0,20,13,0,0,0}, start.
  - Required response: (src0,slot1,merge), (src2,slot2,new), (src3,slot0,merge); done with occupancy=3.
- All-zero batch:
  - Stimulus: src all 0, start.
  - Required response: no grant_valid; done pulses at edge k+1; slots unchanged.
- Start while busy plus spurious release:
  - Stimulus: start pulse during ALLOC; release of an empty slot.
  - Required response: batch unaffected; slot_valid unchanged; grant sequence identical to the baseline run.
- Async reset mid-batch:
  - Stimulus: rst_n low during ALLOC with 2 grants done.
  - Required response: immediately all outputs 0 and state IDLE; after rst_n high, a new start runs a normal batch from empty slots.
